softusb_rx_destuff: RTL and testbench
=====================================

SOFTUSB_RX_DESTUFF -- requirements
Module: softusb_rx_destuff

Interface
REQ-001 Parameter: STUFF_LEN, 6, count of consecutive decoded ones after which one stuffed zero is removed.
REQ-002 usb_clk  in  1  sole clock; all state changes on rising edge.
REQ-003 usb_rst_n  in  1  asynchronous, active-low reset.
REQ-004 rx_en  in  1  receiver enable; low forces IDLE synchronously.
REQ-005 rx_valid  in  1  one-cycle strobe marking a recovered line sample.
REQ-006 rx_j  in  1  sampled differential state, 1=J, 0=K; qualified by rx_valid.
REQ-007 rx_se0  in  1  sampled SE0; qualified by rx_valid; overrides rx_j.
REQ-008 bit_data  out  1  de-stuffed payload bit, wired to the CRC checker's data input.
REQ-009 bit_ce  out  1  one-cycle strobe qualifying bit_data, wired to the CRC checker's crc_ce.
REQ-010 crc_reset  out  1  one-cycle pulse at SYNC completion, wired to the CRC checker's crc_reset.
REQ-011 byte_data  out  8  assembled byte, LSB received first.
REQ-012 byte_strobe  out  1  one-cycle strobe qualifying byte_data.
REQ-013 pkt_active  out  1  high from SYNC completion until EOP or error.
REQ-014 pkt_end  out  1  one-cycle pulse on a completed EOP.
REQ-015 err_stuff  out  1  one-cycle pulse on a bit-stuff violation.
REQ-016 err_align  out  1  qualified by pkt_end; high when EOP arrives with a partial byte pending.

Function
REQ-017 The block shall process only samples with rx_valid=1; all outputs shall be registered and appear exactly one usb_clk after the qualifying sample.
REQ-018 The NRZI decode shall yield 1 when rx_j equals the previous non-SE0 rx_j, else 0; the previous value shall reset to J (1).
REQ-019 FSM states: IDLE, SYNC, DATA, EOP, ERR.
REQ-020 IDLE: a decoded 0 (J->K) shall enter SYNC with the zero counter at 1.
REQ-021 SYNC: each decoded 0 shall increment the zero counter, saturating at 7; a decoded 1 with counter>=5 shall enter DATA, pulse crc_reset, and clear the bit and ones counters; a decoded 1 with counter<5, or SE0, shall return to IDLE.
REQ-022 DATA: a decoded 1 shall increment the ones counter; a decoded 0 shall clear it.
REQ-023 DATA: the sample after STUFF_LEN ones shall be a stuffed bit. A 0 shall be dropped with no bit_ce and no bit count. A 1 shall pulse err_stuff, drop pkt_active and enter ERR.
REQ-024 DATA: every non-stuffed bit shall shift into byte_data at bit 7, shifting toward the LSB; on the 8th bit, byte_strobe shall pulse and the bit counter shall wrap to 0.
REQ-025 bit_ce shall pulse for each non-stuffed bit except the 8 bits of the first byte (PID), so the CRC covers only the post-PID field.
REQ-026 DATA: SE0 shall enter EOP; EOP: further SE0 samples shall hold; a J sample shall pulse pkt_end, with err_align=(bit counter!=0), drop pkt_active and enter IDLE; a K sample shall enter ERR without pkt_end.
REQ-027 ERR: the block shall wait for SE0 followed by J, then enter IDLE; no byte_strobe, bit_ce or pkt_end in ERR.
REQ-028 rx_en=0 shall force IDLE, clear counters and pkt_active, and suppress all strobes in the same cycle; the NRZI history shall be set to J.
REQ-029 Simultaneous SE0 and a due stuffed bit shall be treated as SE0 (EOP takes priority).

Reset
REQ-030 Reset shall put the FSM in IDLE, all counters at 0, NRZI history at 1, and byte_data and every output at 0.
REQ-031 Reset asserted mid-packet shall abort with no pkt_end and no error pulse.

Structure
REQ-032 The FSM state encoding and the STUFF_LEN default shall live in the shared softusb package.
REQ-033 The NRZI decoder plus stuff counter shall be one natural sub-module: softusb_rx_nrzi.

Verification
REQ-034 SYNC, then ACK byte 0xD2, then SE0,SE0,J -> one byte_strobe with 0xD2, zero bit_ce, pkt_end=1, err_align=0.
REQ-035 SYNC, then bytes 0x2D 0x00 0x10, then EOP, with the checker connected -> 3 byte_strobes, 16 bit_ce, crc5_valid=1 at pkt_end.
REQ-036 SYNC, PID, then 0xFF 0xFF with stuffed zeros -> bytes 0xFF,0xFF, the stuffed bits are dropped, 16 bit_ce, err_stuff=0.
REQ-037 Seven consecutive decoded ones in DATA -> err_stuff pulse, pkt_active=0, no further byte_strobe until SE0,J; a new SYNC is then accepted.
REQ-038 SYNC, PID, 4 bits, EOP -> pkt_end=1, err_align=1; only 4 bit_ce after the PID.
REQ-039 usb_rst_n, or rx_en low, asserted mid-byte -> all outputs at 0 next edge, no pkt_end; the next SYNC decodes normally.

Source files
------------

// File: rtl/softusb_rx_destuff_pkg.sv
// Shared types and constants for the soft USB receive path: FSM encoding,
// default bit-stuff run length and the NRZI decode rule.
package softusb_rx_destuff_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_DATA = 3'd2,
        ST_EOP  = 3'd3,
        ST_ERR  = 3'd4
    } rx_state_t;

    localparam int STUFF_LEN_DEFAULT = 6;

    // A SYNC is accepted once at least this many decoded zeros precede its final one.
    localparam logic [2:0] SYNC_MIN_ZEROS = 3'd5;
    localparam logic [2:0] ZERO_CNT_MAX   = 3'd7;

    // NRZI: no line transition decodes to 1, a transition decodes to 0.
    function automatic logic nrzi_decode(input logic cur_j, input logic prev_j);
        return ~(cur_j ^ prev_j);
    endfunction

endpackage

// File: rtl/softusb_rx_destuff_if.sv
// Sample-in / decoded-bit-and-byte-out bundle between the line sampler,
// the de-stuffer and the downstream CRC/packet logic.
interface softusb_rx_destuff_if;

    logic       rx_en;
    logic       rx_valid;
    logic       rx_j;
    logic       rx_se0;

    logic       bit_data;
    logic       bit_ce;
    logic       crc_reset;
    logic [7:0] byte_data;
    logic       byte_strobe;
    logic       pkt_active;
    logic       pkt_end;
    logic       err_stuff;
    logic       err_align;

    modport master (
        output rx_en, rx_valid, rx_j, rx_se0,
        input  bit_data, bit_ce, crc_reset, byte_data, byte_strobe,
               pkt_active, pkt_end, err_stuff, err_align
    );

    modport slave (
        input  rx_en, rx_valid, rx_j, rx_se0,
        output bit_data, bit_ce, crc_reset, byte_data, byte_strobe,
               pkt_active, pkt_end, err_stuff, err_align
    );

endinterface

// File: rtl/softusb_rx_nrzi.sv
// NRZI decoder with line-state history plus the consecutive-ones counter
// that flags when the next data sample is a stuffed bit.
module softusb_rx_nrzi
    import softusb_rx_destuff_pkg::*;
#(
    parameter int STUFF_LEN = STUFF_LEN_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_en,
    input  logic rx_valid,
    input  logic rx_j,
    input  logic rx_se0,
    input  logic cnt_clear,
    input  logic cnt_en,
    output logic dec_bit,
    output logic stuff_due
);

    localparam int CW = $clog2(STUFF_LEN + 1);

    logic          prev_j;
    logic [CW-1:0] ones_cnt;

    assign dec_bit   = nrzi_decode(rx_j, prev_j);
    assign stuff_due = (ones_cnt == CW'(STUFF_LEN));

    // SE0 carries no J/K information, so it leaves the history untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_j   <= 1'b1;
            ones_cnt <= '0;
        end else if (!rx_en) begin
            prev_j   <= 1'b1;
            ones_cnt <= '0;
        end else begin
            if (rx_valid && !rx_se0)
                prev_j <= rx_j;
            if (cnt_clear)
                ones_cnt <= '0;
            else if (cnt_en) begin
                if (!dec_bit)
                    ones_cnt <= '0;
                else if (!stuff_due)
                    ones_cnt <= ones_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/softusb_rx_destuff.sv
// Receive framer: SYNC detection, bit de-stuffing, byte assembly, PID-skipping
// CRC strobe generation and EOP/error handling, all outputs registered.
module softusb_rx_destuff
    import softusb_rx_destuff_pkg::*;
#(
    parameter int STUFF_LEN = STUFF_LEN_DEFAULT
) (
    input  logic                 usb_clk,
    input  logic                 usb_rst_n,
    softusb_rx_destuff_if.slave  bus
);

    rx_state_t  state;
    logic [2:0] zero_cnt;
    logic [2:0] bit_cnt;
    logic       in_pid;
    logic       seen_se0;

    logic       bit_data_r;
    logic       bit_ce_r;
    logic       crc_reset_r;
    logic [7:0] byte_data_r;
    logic       byte_strobe_r;
    logic       pkt_active_r;
    logic       pkt_end_r;
    logic       err_stuff_r;
    logic       err_align_r;

    logic       dec_bit;
    logic       stuff_due;
    logic       cnt_clear;
    logic       cnt_en;

    assign cnt_clear = (state != ST_DATA);
    assign cnt_en    = (state == ST_DATA) && bus.rx_valid && !bus.rx_se0;

    softusb_rx_nrzi #(.STUFF_LEN(STUFF_LEN)) u_nrzi (
        .clk       (usb_clk),
        .rst_n     (usb_rst_n),
        .rx_en     (bus.rx_en),
        .rx_valid  (bus.rx_valid),
        .rx_j      (bus.rx_j),
        .rx_se0    (bus.rx_se0),
        .cnt_clear (cnt_clear),
        .cnt_en    (cnt_en),
        .dec_bit   (dec_bit),
        .stuff_due (stuff_due)
    );

    // Strobes default low every cycle; SE0 is tested before the stuff check so EOP wins.
    always_ff @(posedge usb_clk or negedge usb_rst_n) begin
        if (!usb_rst_n) begin
            state         <= ST_IDLE;
            zero_cnt      <= '0;
            bit_cnt       <= '0;
            in_pid        <= 1'b0;
            seen_se0      <= 1'b0;
            bit_data_r    <= 1'b0;
            bit_ce_r      <= 1'b0;
            crc_reset_r   <= 1'b0;
            byte_data_r   <= '0;
            byte_strobe_r <= 1'b0;
            pkt_active_r  <= 1'b0;
            pkt_end_r     <= 1'b0;
            err_stuff_r   <= 1'b0;
            err_align_r   <= 1'b0;
        end else begin
            bit_ce_r      <= 1'b0;
            crc_reset_r   <= 1'b0;
            byte_strobe_r <= 1'b0;
            pkt_end_r     <= 1'b0;
            err_stuff_r   <= 1'b0;
            err_align_r   <= 1'b0;

            if (!bus.rx_en) begin
                state        <= ST_IDLE;
                zero_cnt     <= '0;
                bit_cnt      <= '0;
                in_pid       <= 1'b0;
                seen_se0     <= 1'b0;
                bit_data_r   <= 1'b0;
                byte_data_r  <= '0;
                pkt_active_r <= 1'b0;
            end else if (bus.rx_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (!bus.rx_se0 && !dec_bit) begin
                            state    <= ST_SYNC;
                            zero_cnt <= 3'd1;
                        end
                    end
                    ST_SYNC: begin
                        if (bus.rx_se0)
                            state <= ST_IDLE;
                        else if (!dec_bit) begin
                            if (zero_cnt != ZERO_CNT_MAX)
                                zero_cnt <= zero_cnt + 3'd1;
                        end else if (zero_cnt >= SYNC_MIN_ZEROS) begin
                            state        <= ST_DATA;
                            crc_reset_r  <= 1'b1;
                            bit_cnt      <= '0;
                            in_pid       <= 1'b1;
                            pkt_active_r <= 1'b1;
                        end else
                            state <= ST_IDLE;
                    end
                    ST_DATA: begin
                        if (bus.rx_se0)
                            state <= ST_EOP;
                        else if (stuff_due) begin
                            if (dec_bit) begin
                                err_stuff_r  <= 1'b1;
                                pkt_active_r <= 1'b0;
                                seen_se0     <= 1'b0;
                                state        <= ST_ERR;
                            end
                        end else begin
                            byte_data_r <= {dec_bit, byte_data_r[7:1]};
                            bit_data_r  <= dec_bit;
                            bit_ce_r    <= !in_pid;
                            bit_cnt     <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                byte_strobe_r <= 1'b1;
                                in_pid        <= 1'b0;
                            end
                        end
                    end
                    ST_EOP: begin
                        if (!bus.rx_se0) begin
                            pkt_active_r <= 1'b0;
                            if (bus.rx_j) begin
                                pkt_end_r   <= 1'b1;
                                err_align_r <= (bit_cnt != 3'd0);
                                state       <= ST_IDLE;
                            end else begin
                                seen_se0 <= 1'b0;
                                state    <= ST_ERR;
                            end
                        end
                    end
                    ST_ERR: begin
                        if (bus.rx_se0)
                            seen_se0 <= 1'b1;
                        else if (seen_se0 && bus.rx_j)
                            state <= ST_IDLE;
                        else
                            seen_se0 <= 1'b0;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.bit_data    = bit_data_r;
    assign bus.bit_ce      = bit_ce_r;
    assign bus.crc_reset   = crc_reset_r;
    assign bus.byte_data   = byte_data_r;
    assign bus.byte_strobe = byte_strobe_r;
    assign bus.pkt_active  = pkt_active_r;
    assign bus.pkt_end     = pkt_end_r;
    assign bus.err_stuff   = err_stuff_r;
    assign bus.err_align   = err_align_r;

endmodule

// File: tb/tb_softusb_rx_destuff.sv
// Self-checking bench for softusb_rx_destuff: NRZI/stuffing line encoder,
// byte scoreboard and a CRC5 model fed from bit_data/bit_ce.
module tb_softusb_rx_destuff;

    logic usb_clk;
    logic usb_rst_n;

    softusb_rx_destuff_if bus ();

    softusb_rx_destuff dut (
        .usb_clk   (usb_clk),
        .usb_rst_n (usb_rst_n),
        .bus       (bus)
    );

    initial usb_clk = 1'b0;
    always #5 usb_clk = ~usb_clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_bytes[$];
    int   n_bytes     = 0;
    int   n_bitce     = 0;
    int   n_pkt_end   = 0;
    int   n_err_stuff = 0;
    int   n_crc_reset = 0;
    logic last_align  = 1'b0;
    logic [4:0] crc5        = 5'h1F;
    logic [4:0] crc_at_end  = 5'h00;

    logic line_j   = 1'b1;
    int   ones_run = 0;

    // One line sample, then observe the registered response one edge later.
    task automatic send_sample(input logic j, input logic se0);
        logic [7:0] e;
        logic       fb;
        @(negedge usb_clk);
        bus.rx_valid = 1'b1;
        bus.rx_j     = j;
        bus.rx_se0   = se0;
        @(negedge usb_clk);
        bus.rx_valid = 1'b0;
        bus.rx_se0   = 1'b0;
        if (bus.byte_strobe) begin
            n_bytes++;
            checks++;
            if (exp_bytes.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_byte: got %02h expected no byte_strobe", bus.byte_data);
            end else begin
                e = exp_bytes.pop_front();
                if (bus.byte_data !== e) begin
                    errors++;
                    $display("[TB] FAIL byte_data: got %02h expected %02h", bus.byte_data, e);
                end
            end
        end
        if (bus.crc_reset) begin
            n_crc_reset++;
            crc5 = 5'h1F;
        end
        if (bus.bit_ce) begin
            n_bitce++;
            fb   = bus.bit_data ^ crc5[4];
            crc5 = {crc5[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
        end
        if (bus.err_stuff) n_err_stuff++;
        if (bus.pkt_end) begin
            n_pkt_end++;
            last_align = bus.err_align;
            crc_at_end = crc5;
        end
    endtask

    task automatic send_raw(input logic b);
        if (!b) line_j = ~line_j;
        send_sample(line_j, 1'b0);
    endtask

    task automatic send_data_bit(input logic b);
        if (ones_run == 6) begin
            send_raw(1'b0);
            ones_run = 0;
        end
        send_raw(b);
        ones_run = b ? ones_run + 1 : 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit expect_strobe);
        if (expect_strobe) exp_bytes.push_back(b);
        for (int i = 0; i < 8; i++) send_data_bit(b[i]);
    endtask

    task automatic send_sync(input int zeros);
        for (int i = 0; i < zeros; i++) send_raw(1'b0);
        send_raw(1'b1);
        ones_run = 0;
    endtask

    task automatic send_eop();
        send_sample(1'b0, 1'b1);
        send_sample(1'b0, 1'b1);
        line_j = 1'b1;
        send_sample(1'b1, 1'b0);
    endtask

    function automatic logic [15:0] all_outputs();
        return {bus.bit_data, bus.bit_ce, bus.crc_reset, bus.byte_data, bus.byte_strobe,
                bus.pkt_active, bus.pkt_end, bus.err_stuff, bus.err_align};
    endfunction

    task automatic test_reset();
        bus.rx_en = 1'b1; bus.rx_valid = 1'b0; bus.rx_j = 1'b1; bus.rx_se0 = 1'b0;
        usb_rst_n = 1'b0;
        repeat (3) @(negedge usb_clk);
        checks++;
        if (all_outputs() !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %04h expected 0000", all_outputs());
        end
        usb_rst_n = 1'b1;
        line_j    = 1'b1;
        @(negedge usb_clk);
    endtask

    task automatic test_ack();
        int b0, c0, p0, r0;
        b0 = n_bytes; c0 = n_bitce; p0 = n_pkt_end; r0 = n_crc_reset;
        send_sync(7);
        checks++;
        if (bus.pkt_active !== 1'b1 || n_crc_reset - r0 != 1) begin
            errors++;
            $display("[TB] FAIL ack_sync: got pkt_active=%0b crc_reset=%0d expected 1 and 1",
                     bus.pkt_active, n_crc_reset - r0);
        end
        send_byte(8'hD2, 1'b1);
        send_eop();
        checks++;
        if (n_bytes - b0 != 1) begin
            errors++; $display("[TB] FAIL ack_bytes: got %0d expected 1", n_bytes - b0);
        end
        checks++;
        if (n_bitce - c0 != 0) begin
            errors++; $display("[TB] FAIL ack_bit_ce: got %0d expected 0", n_bitce - c0);
        end
        checks++;
        if (n_pkt_end - p0 != 1 || last_align !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ack_eop: got pkt_end=%0d err_align=%0b expected 1 and 0",
                     n_pkt_end - p0, last_align);
        end
        checks++;
        if (bus.pkt_active !== 1'b0) begin
            errors++; $display("[TB] FAIL ack_inactive: got %0b expected 0", bus.pkt_active);
        end
    endtask

    task automatic test_crc5();
        int b0, c0, p0;
        b0 = n_bytes; c0 = n_bitce; p0 = n_pkt_end;
        send_sync(7);
        send_byte(8'h2D, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h10, 1'b1);
        send_eop();
        checks++;
        if (n_bytes - b0 != 3) begin
            errors++; $display("[TB] FAIL crc_bytes: got %0d expected 3", n_bytes - b0);
        end
        checks++;
        if (n_bitce - c0 != 16) begin
            errors++; $display("[TB] FAIL crc_bit_ce: got %0d expected 16", n_bitce - c0);
        end
        checks++;
        if (n_pkt_end - p0 != 1 || crc_at_end !== 5'b01100) begin
            errors++;
            $display("[TB] FAIL crc5_valid: got pkt_end=%0d residual=%05b expected 1 and 01100",
                     n_pkt_end - p0, crc_at_end);
        end
    endtask

    task automatic test_stuffing();
        int c0, p0, s0;
        c0 = n_bitce; p0 = n_pkt_end; s0 = n_err_stuff;
        send_sync(7);
        send_byte(8'hC3, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'hFF, 1'b1);
        // six trailing ones leave a stuffed bit due when SE0 arrives
        send_eop();
        checks++;
        if (n_bitce - c0 != 16) begin
            errors++; $display("[TB] FAIL stuff_bit_ce: got %0d expected 16", n_bitce - c0);
        end
        checks++;
        if (n_err_stuff - s0 != 0) begin
            errors++; $display("[TB] FAIL stuff_no_err: got %0d expected 0", n_err_stuff - s0);
        end
        checks++;
        if (n_pkt_end - p0 != 1 || last_align !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stuff_eop: got pkt_end=%0d err_align=%0b expected 1 and 0",
                     n_pkt_end - p0, last_align);
        end
    endtask

    task automatic test_stuff_error();
        int b0, p0, s0;
        b0 = n_bytes; p0 = n_pkt_end; s0 = n_err_stuff;
        send_sync(7);
        send_byte(8'h69, 1'b1);
        for (int i = 0; i < 7; i++) send_raw(1'b1);
        checks++;
        if (n_err_stuff - s0 != 1 || bus.pkt_active !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stuff_violation: got err_stuff=%0d pkt_active=%0b expected 1 and 0",
                     n_err_stuff - s0, bus.pkt_active);
        end
        for (int i = 0; i < 16; i++) send_raw(i[0]);
        send_eop();
        checks++;
        if (n_bytes - b0 != 1 || n_pkt_end - p0 != 0) begin
            errors++;
            $display("[TB] FAIL err_quiet: got bytes=%0d pkt_end=%0d expected 1 and 0",
                     n_bytes - b0, n_pkt_end - p0);
        end
        send_sync(7);
        send_byte(8'hD2, 1'b1);
        send_eop();
        checks++;
        if (n_bytes - b0 != 2 || n_pkt_end - p0 != 1) begin
            errors++;
            $display("[TB] FAIL err_recover: got bytes=%0d pkt_end=%0d expected 2 and 1",
                     n_bytes - b0, n_pkt_end - p0);
        end
    endtask

    task automatic test_align();
        int c0, p0;
        logic [3:0] tail;
        tail = 4'b1101;
        send_sync(7);
        send_byte(8'hE1, 1'b1);
        c0 = n_bitce; p0 = n_pkt_end;
        for (int i = 0; i < 4; i++) send_data_bit(tail[i]);
        send_eop();
        checks++;
        if (n_bitce - c0 != 4) begin
            errors++; $display("[TB] FAIL align_bit_ce: got %0d expected 4", n_bitce - c0);
        end
        checks++;
        if (n_pkt_end - p0 != 1 || last_align !== 1'b1) begin
            errors++;
            $display("[TB] FAIL align_eop: got pkt_end=%0d err_align=%0b expected 1 and 1",
                     n_pkt_end - p0, last_align);
        end
    endtask

    task automatic test_sync_boundary();
        int b0, p0, r0;
        b0 = n_bytes; p0 = n_pkt_end; r0 = n_crc_reset;
        send_sync(4);
        send_byte(8'hA5, 1'b0);
        send_eop();
        checks++;
        if (n_crc_reset - r0 != 0 || n_bytes - b0 != 0 || n_pkt_end - p0 != 0) begin
            errors++;
            $display("[TB] FAIL short_sync: got crc_reset=%0d bytes=%0d pkt_end=%0d expected 0 0 0",
                     n_crc_reset - r0, n_bytes - b0, n_pkt_end - p0);
        end
        send_sync(5);
        send_byte(8'h5A, 1'b1);
        send_eop();
        checks++;
        if (n_crc_reset - r0 != 1 || n_bytes - b0 != 1 || n_pkt_end - p0 != 1) begin
            errors++;
            $display("[TB] FAIL min_sync: got crc_reset=%0d bytes=%0d pkt_end=%0d expected 1 1 1",
                     n_crc_reset - r0, n_bytes - b0, n_pkt_end - p0);
        end
    endtask

    task automatic test_abort();
        int p0;
        p0 = n_pkt_end;
        send_sync(7);
        send_byte(8'hD2, 1'b1);
        send_data_bit(1'b1); send_data_bit(1'b1); send_data_bit(1'b1);
        @(negedge usb_clk);
        usb_rst_n = 1'b0;
        @(negedge usb_clk);
        checks++;
        if (all_outputs() !== 16'h0) begin
            errors++; $display("[TB] FAIL rst_abort: got %04h expected 0000", all_outputs());
        end
        usb_rst_n = 1'b1;
        line_j    = 1'b1;
        send_sync(7);
        send_byte(8'h4B, 1'b1);
        send_eop();
        checks++;
        if (n_pkt_end - p0 != 1 || last_align !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_recover: got pkt_end=%0d err_align=%0b expected 1 and 0",
                     n_pkt_end - p0, last_align);
        end

        p0 = n_pkt_end;
        send_sync(7);
        send_byte(8'hC3, 1'b1);
        send_data_bit(1'b1); send_data_bit(1'b0); send_data_bit(1'b1);
        @(negedge usb_clk);
        bus.rx_en    = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_j     = ~line_j;
        @(negedge usb_clk);
        bus.rx_valid = 1'b0;
        checks++;
        if (all_outputs() !== 16'h0) begin
            errors++; $display("[TB] FAIL en_abort: got %04h expected 0000", all_outputs());
        end
        bus.rx_en = 1'b1;
        line_j    = 1'b1;
        send_sync(7);
        send_byte(8'h5A, 1'b1);
        send_eop();
        checks++;
        if (n_pkt_end - p0 != 1 || last_align !== 1'b0) begin
            errors++;
            $display("[TB] FAIL en_recover: got pkt_end=%0d err_align=%0b expected 1 and 0",
                     n_pkt_end - p0, last_align);
        end
    endtask

    initial begin
        test_reset();
        test_ack();
        test_crc5();
        test_stuffing();
        test_stuff_error();
        test_align();
        test_sync_boundary();
        test_abort();
        checks++;
        if (exp_bytes.size() != 0) begin
            errors++;
            $display("[TB] FAIL missing_bytes: got %0d pending expected 0", exp_bytes.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
